// File: rtl/alu_pkg.sv
// Shared ALU operation encoding and decode helpers for the execute stage.
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_AND  = 3'd0;
  localparam alu_op_t ALU_OR   = 3'd1;
  localparam alu_op_t ALU_ADD  = 3'd2;
  localparam alu_op_t ALU_SUB  = 3'd3;
  localparam alu_op_t ALU_SLT  = 3'd4;
  localparam alu_op_t ALU_SLTU = 3'd5;
  localparam alu_op_t ALU_NOR  = 3'd6;
  localparam alu_op_t ALU_XOR  = 3'd7;

  // Ops that compute a + ~b + 1; this also doubles as the stage-0 carry-in.
  function automatic logic op_bnegate(alu_op_t op);
    return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

endpackage

// File: rtl/alu_chunk.sv
// Combinational CHUNK-bit ALU slice: ripple adder plus per-chunk logical ops.
module alu_chunk
  import alu_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bnegate,
  input  logic             cin,
  input  alu_op_t          op,
  output logic [CHUNK-1:0] result,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK-1:0] b_eff;

  always_comb begin
    b_eff         = bnegate ? ~b : b;
    {cout, sum}   = {1'b0, a} + {1'b0, b_eff} + (CHUNK + 1)'(cin);
    // Carry into the top bit recovered from the top bit's sum equation.
    c_msb         = sum[CHUNK-1] ^ a[CHUNK-1] ^ b_eff[CHUNK-1];
    result        = sum;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_XOR: result = a ^ b;
      default: result = sum;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined W-bit ALU: one CHUNK-bit ripple slice per register stage, carry
// crossing stages through the pipeline registers, valid/ready on both sides.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  alu_op_t          in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;

  if ((CHUNK == 0) || (STAGES == 0) || ((WIDTH % CHUNK) != 0)) begin : g_width_check
    $fatal(1, "alu_pipe: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Stage registers; index k holds the state leaving slice k.
  logic             r_vld [STAGES];
  alu_op_t          r_op  [STAGES];
  logic [TAG_W-1:0] r_tag [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_res [STAGES];
  logic             r_cy  [STAGES];
  logic             r_zero, r_cout, r_ovf;

  // Inputs seen by slice k and its results.
  logic             si_vld [STAGES];
  alu_op_t          si_op  [STAGES];
  logic [TAG_W-1:0] si_tag [STAGES];
  logic [WIDTH-1:0] si_a   [STAGES];
  logic [WIDTH-1:0] si_b   [STAGES];
  logic [WIDTH-1:0] si_res [STAGES];
  logic             si_cin [STAGES];
  logic [CHUNK-1:0] ch_res [STAGES];
  logic [CHUNK-1:0] ch_sum [STAGES];
  logic             ch_cout[STAGES];
  logic             ch_cmsb[STAGES];
  logic [WIDTH-1:0] nx_res [STAGES];

  logic             adv;
  logic             cout_raw, ovf_raw, slt_bit, sltu_bit;
  logic [WIDTH-1:0] fin_res;
  logic             fin_zero, fin_cout, fin_ovf;

  assign adv      = ~r_vld[LAST] | out_ready;
  assign in_ready = adv;

  // Slice k consumes the issue port (k=0) or the previous stage register.
  always_comb begin
    si_vld[0] = in_valid;
    si_op[0]  = in_op;
    si_tag[0] = in_tag;
    si_a[0]   = in_a;
    si_b[0]   = in_b;
    si_res[0] = '0;
    si_cin[0] = op_bnegate(in_op);
    for (int k = 1; k < STAGES; k++) begin
      si_vld[k] = r_vld[k-1];
      si_op[k]  = r_op[k-1];
      si_tag[k] = r_tag[k-1];
      si_a[k]   = r_a[k-1];
      si_b[k]   = r_b[k-1];
      si_res[k] = r_res[k-1];
      si_cin[k] = r_cy[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    alu_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a       (si_a[k][k*CHUNK +: CHUNK]),
      .b       (si_b[k][k*CHUNK +: CHUNK]),
      .bnegate (op_bnegate(si_op[k])),
      .cin     (si_cin[k]),
      .op      (si_op[k]),
      .result  (ch_res[k]),
      .sum     (ch_sum[k]),
      .cout    (ch_cout[k]),
      .c_msb   (ch_cmsb[k])
    );
  end

  // Merge each slice's chunk into the skewed result; the last slice also
  // finalises compares and flags.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nx_res[k]                    = si_res[k];
      nx_res[k][k*CHUNK +: CHUNK]  = ch_res[k];
    end
    cout_raw = ch_cout[LAST];
    ovf_raw  = cout_raw ^ ch_cmsb[LAST];
    slt_bit  = ch_sum[LAST][CHUNK-1] ^ ovf_raw;
    sltu_bit = ~cout_raw;
    fin_res  = nx_res[LAST];
    fin_cout = 1'b0;
    fin_ovf  = 1'b0;
    case (si_op[LAST])
      ALU_ADD, ALU_SUB: begin
        fin_cout = cout_raw;
        fin_ovf  = ovf_raw;
      end
      ALU_SLT: begin
        fin_res  = WIDTH'(slt_bit);
        fin_cout = cout_raw;
      end
      ALU_SLTU: begin
        fin_res  = WIDTH'(sltu_bit);
        fin_cout = cout_raw;
      end
      default: ;
    endcase
    fin_zero = (fin_res == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_op[k]  <= ALU_AND;
        r_tag[k] <= '0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_res[k] <= '0;
        r_cy[k]  <= 1'b0;
      end
      r_zero <= 1'b0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= si_vld[k];
        r_op[k]  <= si_op[k];
        r_tag[k] <= si_tag[k];
        r_a[k]   <= si_a[k];
        r_b[k]   <= si_b[k];
        r_res[k] <= nx_res[k];
        r_cy[k]  <= ch_cout[k];
      end
      r_res[LAST] <= fin_res;
      r_zero      <= fin_zero;
      r_cout      <= fin_cout;
      r_ovf       <= fin_ovf;
    end
  end

  assign out_valid  = r_vld[LAST];
  assign out_result = r_res[LAST];
  assign out_tag    = r_tag[LAST];
  assign out_zero   = r_zero;
  assign out_cout   = r_cout;
  assign out_ovf    = r_ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=32, CHUNK=8 (latency 4).
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CHUNK = 8;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned LAT   = 4;
  localparam int unsigned N_STREAM = 20;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  alu_op_t          in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic             out_cout;
  logic             out_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  alu_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag),
    .out_zero  (out_zero),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with out_ready held high, then check latency, result and flags.
  task automatic run_op(input string name, input alu_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp_res, input logic ez, input logic ec,
                        input logic eo);
    int lat;
    out_ready = 1'b1;
    check({name, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({name, ".out_valid"}, 64'(out_valid), 64'd1);
    check({name, ".latency"}, 64'(lat), 64'(LAT));
    check({name, ".result"}, 64'(out_result), 64'(exp_res));
    check({name, ".tag"}, 64'(out_tag), 64'(tag));
    check({name, ".zero"}, 64'(out_zero), 64'(ez));
    check({name, ".cout"}, 64'(out_cout), 64'(ec));
    check({name, ".ovf"}, 64'(out_ovf), 64'(eo));
    tick();
  endtask

  function automatic logic [31:0] stream_model(input alu_op_t op, input logic [31:0] a,
                                               input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      default: return a ^ b;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_q[$];
    logic [4:0]  tag_q[$];
    logic        held_v;
    logic [31:0] held_res;
    logic [4:0]  held_tag;
    logic [31:0] sa, sb, e_res;
    logic [4:0]  e_tag;
    alu_op_t     sop;
    int          sent, got, cyc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = ALU_AND; in_tag = '0;
    repeat (3) tick();
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.result", 64'(out_result), 64'd0);
    check("reset.flags", 64'({out_zero, out_cout, out_ovf}), 64'd0);
    rst = 1'b0;
    tick();
    check("reset.in_ready", 64'(in_ready), 64'd1);

    // Directed single ops.
    run_op("add_ovf",   ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd1,  32'h80000000, 1'b0, 1'b0, 1'b1);
    run_op("add_carry", ALU_ADD,  32'h000000FF, 32'h00000001, 5'd2,  32'h00000100, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap",  ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 5'd3,  32'h00000000, 1'b1, 1'b1, 1'b0);
    run_op("sub_zero",  ALU_SUB,  32'h00000005, 32'h00000005, 5'd4,  32'h00000000, 1'b1, 1'b1, 1'b0);
    run_op("sub_neg",   ALU_SUB,  32'h00000000, 32'h00000001, 5'd5,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    run_op("sub_ovf",   ALU_SUB,  32'h80000000, 32'h00000001, 5'd6,  32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
    run_op("slt_neg",   ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd7,  32'h00000001, 1'b0, 1'b1, 1'b0);
    run_op("sltu_big",  ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd8,  32'h00000000, 1'b1, 1'b1, 1'b0);
    run_op("sltu_small",ALU_SLTU, 32'h00000001, 32'hFFFFFFFF, 5'd9,  32'h00000001, 1'b0, 1'b0, 1'b0);
    run_op("slt_ovf",   ALU_SLT,  32'h80000000, 32'h00000001, 5'd10, 32'h00000001, 1'b0, 1'b1, 1'b0);
    run_op("slt_pos",   ALU_SLT,  32'h7FFFFFFF, 32'hFFFFFFFF, 5'd11, 32'h00000000, 1'b1, 1'b0, 1'b0);
    run_op("and",       ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd12, 32'hF000F000, 1'b0, 1'b0, 1'b0);
    run_op("or",        ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd13, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
    run_op("nor",       ALU_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd14, 32'h000F000F, 1'b0, 1'b0, 1'b0);
    run_op("xor",       ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd15, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream with periodic back-pressure.
    held_v = 1'b0; held_res = '0; held_tag = '0;
    sent = 0; got = 0; cyc = 0;
    while (got < int'(N_STREAM) && cyc < 300) begin
      out_ready = ((cyc % 3) != 0);
      if (sent < int'(N_STREAM)) begin
        sop      = (sent % 3 == 0) ? ALU_ADD : ((sent % 3 == 1) ? ALU_SUB : ALU_XOR);
        sa       = 32'h12345678 * 32'(sent + 1);
        sb       = 32'hFEDCBA98 ^ (32'(sent) << 4);
        in_valid = 1'b1;
        in_op    = sop;
        in_a     = sa;
        in_b     = sb;
        in_tag   = 5'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held_v) begin
        check("stall.valid", 64'(out_valid), 64'd1);
        check("stall.result", 64'(out_result), 64'(held_res));
        check("stall.tag", 64'(out_tag), 64'(held_tag));
      end
      check("stream.in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      held_v   = out_valid && !out_ready;
      held_res = out_result;
      held_tag = out_tag;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream.extra", 64'(out_valid), 64'd0);
        end else begin
          e_res = exp_q.pop_front();
          e_tag = tag_q.pop_front();
          check("stream.result", 64'(out_result), 64'(e_res));
          check("stream.tag", 64'(out_tag), 64'(e_tag));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(stream_model(in_op, in_a, in_b));
        tag_q.push_back(in_tag);
        sent++;
      end
      tick();
      cyc++;
    end
    check("stream.count", 64'(got), 64'(N_STREAM));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      tick();
      check("stream.no_dup", 64'(out_valid), 64'd0);
    end

    // Reset with three ops in flight; none may complete.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_op    = ALU_ADD;
      in_a     = 32'hFFFFFFFF;
      in_b     = 32'(i + 1);
      in_tag   = 5'(20 + i);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.result", 64'(out_result), 64'd0);
    check("rst.tag", 64'(out_tag), 64'd0);
    check("rst.flags", 64'({out_zero, out_cout, out_ovf}), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    repeat (8) begin
      tick();
      check("rst.no_ghost", 64'(out_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
